// File: rtl/channel_fifo_rr_scheduler_if.sv
// Bundle of the per-requester input streams, the shared downstream pkt/meta path and the status outputs.
// The scheduler connects through the master modport. The FIFO bank and consumer side connect through the slave modport.
interface channel_fifo_rr_scheduler_if #(
  parameter int NUM_IN  = 4,
  parameter int PKT_W   = 512,
  parameter int EMPTY_W = 6,
  parameter int META_W  = 128
);
  localparam int CH_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]         in_pkt_sop;
  logic [NUM_IN-1:0]         in_pkt_eop;
  logic [NUM_IN*PKT_W-1:0]   in_pkt_data;
  logic [NUM_IN*EMPTY_W-1:0] in_pkt_empty;
  logic [NUM_IN-1:0]         in_pkt_valid;
  logic [NUM_IN-1:0]         in_pkt_ready;
  logic [NUM_IN*META_W-1:0]  in_meta_data;
  logic [NUM_IN-1:0]         in_meta_valid;
  logic [NUM_IN-1:0]         in_meta_ready;

  logic                      out_pkt_sop;
  logic                      out_pkt_eop;
  logic [PKT_W-1:0]          out_pkt_data;
  logic [EMPTY_W-1:0]        out_pkt_empty;
  logic                      out_pkt_valid;
  logic                      out_pkt_ready;
  logic                      out_pkt_almost_full;
  logic [CH_W-1:0]           out_pkt_channel;
  logic [META_W-1:0]         out_meta_data;
  logic                      out_meta_valid;
  logic                      out_meta_ready;
  logic [CH_W-1:0]           out_meta_channel;

  logic [NUM_IN*32-1:0]      grant_cnt;
  logic                      protocol_err;

  modport master (
    input  in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty, in_pkt_valid,
    input  in_meta_data, in_meta_valid,
    output in_pkt_ready, in_meta_ready,
    output out_pkt_sop, out_pkt_eop, out_pkt_data, out_pkt_empty, out_pkt_valid, out_pkt_channel,
    input  out_pkt_ready, out_pkt_almost_full,
    output out_meta_data, out_meta_valid, out_meta_channel,
    input  out_meta_ready,
    output grant_cnt, protocol_err
  );

  modport slave (
    output in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty, in_pkt_valid,
    output in_meta_data, in_meta_valid,
    input  in_pkt_ready, in_meta_ready,
    input  out_pkt_sop, out_pkt_eop, out_pkt_data, out_pkt_empty, out_pkt_valid, out_pkt_channel,
    output out_pkt_ready, out_pkt_almost_full,
    input  out_meta_data, out_meta_valid, out_meta_channel,
    output out_meta_ready,
    input  grant_cnt, protocol_err
  );
endinterface

// File: rtl/channel_fifo_rr_scheduler.sv
// Packet-atomic round-robin scheduler. It grants one channel, forwards that channel's meta word,
// then forwards its packet up to eop before it arbitrates again. It also keeps per-channel packet counts.
module channel_fifo_rr_scheduler #(
  parameter int NUM_IN  = 4,
  parameter int PKT_W   = 512,
  parameter int EMPTY_W = 6,
  parameter int META_W  = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  channel_fifo_rr_scheduler_if.master  bus
);
  localparam int CH_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_META = 2'd1;
  localparam logic [1:0] ST_PKT  = 2'd2;

  logic [1:0]          state;
  logic [CH_W-1:0]     grant;
  logic [CH_W-1:0]     last_grant;
  logic [CH_W-1:0]     next_grant;
  logic                found;
  logic                first_flit;
  logic                err;
  logic [31:0]         cnt [NUM_IN];
  logic [NUM_IN-1:0]   req;
  logic [CH_W:0]       search_idx;

  logic                sel_sop;
  logic                sel_eop;
  logic                sel_valid;
  logic [PKT_W-1:0]    sel_data;
  logic [EMPTY_W-1:0]  sel_empty;
  logic [META_W-1:0]   sel_meta;
  logic [NUM_IN-1:0]   pkt_ready;
  logic [NUM_IN-1:0]   meta_ready;
  logic [NUM_IN*32-1:0] cnt_flat;
  logic                accept;

  assign req = bus.in_meta_valid & bus.in_pkt_valid & bus.in_pkt_sop;

  // The first requester found, scanning cyclically from last_grant+1, wins.
  always_comb begin : rr_search
    // NOTE: every combinational output gets a default before the loop, so no path can infer a latch.
    found      = 1'b0;
    next_grant = grant;
    search_idx = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      search_idx = {1'b0, last_grant} + (CH_W+1)'(k);
      if (search_idx >= (CH_W+1)'(NUM_IN))
        search_idx = search_idx - (CH_W+1)'(NUM_IN);
      if (!found && req[search_idx[CH_W-1:0]]) begin
        found      = 1'b1;
        next_grant = search_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin : grant_mux
    sel_sop    = 1'b0;
    sel_eop    = 1'b0;
    sel_valid  = 1'b0;
    sel_data   = '0;
    sel_empty  = '0;
    sel_meta   = '0;
    pkt_ready  = '0;
    meta_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_flat[i*32 +: 32] = cnt[i];
      if (grant == CH_W'(i)) begin
        sel_sop       = bus.in_pkt_sop[i];
        sel_eop       = bus.in_pkt_eop[i];
        sel_valid     = bus.in_pkt_valid[i];
        sel_data      = bus.in_pkt_data[i*PKT_W +: PKT_W];
        sel_empty     = bus.in_pkt_empty[i*EMPTY_W +: EMPTY_W];
        sel_meta      = bus.in_meta_data[i*META_W +: META_W];
        pkt_ready[i]  = (state == ST_PKT)  && bus.out_pkt_ready;
        meta_ready[i] = (state == ST_META) && bus.out_meta_ready;
      end
    end
  end

  assign accept = (state == ST_PKT) && sel_valid && bus.out_pkt_ready;

  assign bus.in_pkt_ready     = pkt_ready;
  assign bus.in_meta_ready    = meta_ready;
  assign bus.out_meta_valid   = (state == ST_META);
  assign bus.out_meta_data    = sel_meta;
  assign bus.out_meta_channel = grant;
  assign bus.out_pkt_valid    = (state == ST_PKT) && sel_valid;
  assign bus.out_pkt_sop      = sel_sop;
  assign bus.out_pkt_eop      = sel_eop;
  assign bus.out_pkt_data     = sel_data;
  assign bus.out_pkt_empty    = sel_empty;
  assign bus.out_pkt_channel  = grant;
  assign bus.grant_cnt        = cnt_flat;
  assign bus.protocol_err     = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_IN - 1);
      first_flit <= 1'b0;
      err        <= 1'b0;
      // NOTE: the counters are architecturally visible, so each one is cleared on reset rather than left undefined.
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking, so every branch reads this cycle's values.
      case (state)
        ST_IDLE: begin
          if (found && !bus.out_pkt_almost_full) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= ST_META;
          end
        end
        ST_META: begin
          if (bus.out_meta_ready) begin
            state      <= ST_PKT;
            first_flit <= 1'b1;
          end
        end
        ST_PKT: begin
          if (accept) begin
            first_flit <= 1'b0;
            // A sop on a later flit, or no sop on the first flit, is a framing error. The packet still flows.
            if (sel_sop != first_flit) err <= 1'b1;
            if (sel_eop) begin
              cnt[grant] <= cnt[grant] + 32'd1;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_channel_fifo_rr_scheduler.sv
// Directed bench for channel_fifo_rr_scheduler: per-channel source queues, a handshake monitor and table-driven checks.
module tb_channel_fifo_rr_scheduler;
  localparam int N     = 4;
  localparam int PW    = 16;
  localparam int EW    = 6;
  localparam int MW    = 16;
  localparam int DEPTH = 64;
  localparam int LOGN  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   toggle = 1'b0;
  bit   af = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  channel_fifo_rr_scheduler_if #(.NUM_IN(N), .PKT_W(PW), .EMPTY_W(EW), .META_W(MW)) bus ();

  channel_fifo_rr_scheduler #(.NUM_IN(N), .PKT_W(PW), .EMPTY_W(EW), .META_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Source storage: the initial block owns the write pointers, the driver owns the read pointers.
  logic [PW-1:0] f_data  [N][DEPTH];
  logic          f_sop   [N][DEPTH];
  logic          f_eop   [N][DEPTH];
  logic [MW-1:0] m_store [N][DEPTH];
  int wr [N];
  int mwr [N];
  int rd [N];
  int mrd [N];
  logic [N-1:0] pkt_fire;
  logic [N-1:0] meta_fire;

  // Output log filled by the monitor.
  int cyc = 0;
  int mon_n = 0;
  int mon_eop_n = 0;
  int meta_n = 0;
  logic [1:0]    mon_ch    [LOGN];
  logic          mon_sop   [LOGN];
  logic          mon_eop   [LOGN];
  logic [PW-1:0] mon_data  [LOGN];
  logic [EW-1:0] mon_empty [LOGN];
  logic [1:0]    meta_ch   [LOGN];
  logic [MW-1:0] meta_data [LOGN];
  int            meta_cyc  [LOGN];

  always @(posedge clk) begin : driver
    logic [N-1:0]    pv, ps, pe, mv;
    logic [N*PW-1:0] pd;
    logic [N*EW-1:0] pm;
    logic [N*MW-1:0] md;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        rd[i]  = wr[i];
        mrd[i] = mwr[i];
      end else begin
        if (pkt_fire[i]  === 1'b1 && rd[i]  != wr[i])  rd[i]++;
        if (meta_fire[i] === 1'b1 && mrd[i] != mwr[i]) mrd[i]++;
      end
    end
    pv = '0; ps = '0; pe = '0; mv = '0; pd = '0; pm = '0; md = '0;
    for (int i = 0; i < N; i++) begin
      pv[i] = (rd[i] != wr[i]);
      if (pv[i]) begin
        ps[i]             = f_sop[i][rd[i]];
        pe[i]             = f_eop[i][rd[i]];
        pd[i*PW +: PW]    = f_data[i][rd[i]];
        pm[i*EW +: EW]    = f_data[i][rd[i]][EW-1:0];
      end
      mv[i] = (mrd[i] != mwr[i]);
      if (mv[i]) md[i*MW +: MW] = m_store[i][mrd[i]];
    end
    bus.in_pkt_valid        = pv;
    bus.in_pkt_sop          = ps;
    bus.in_pkt_eop          = pe;
    bus.in_pkt_data         = pd;
    bus.in_pkt_empty        = pm;
    bus.in_meta_valid       = mv;
    bus.in_meta_data        = md;
    bus.out_pkt_ready       = toggle ? ~bus.out_pkt_ready : 1'b1;
    bus.out_meta_ready      = 1'b1;
    bus.out_pkt_almost_full = af;
  end

  always @(negedge clk) begin : monitor
    cyc++;
    pkt_fire  = bus.in_pkt_valid  & bus.in_pkt_ready;
    meta_fire = bus.in_meta_valid & bus.in_meta_ready;
    if (!rst && bus.out_pkt_valid === 1'b1 && bus.out_pkt_ready === 1'b1 && mon_n < LOGN) begin
      mon_ch[mon_n]    = bus.out_pkt_channel;
      mon_sop[mon_n]   = bus.out_pkt_sop;
      mon_eop[mon_n]   = bus.out_pkt_eop;
      mon_data[mon_n]  = bus.out_pkt_data;
      mon_empty[mon_n] = bus.out_pkt_empty;
      if (bus.out_pkt_eop === 1'b1) mon_eop_n++;
      mon_n++;
    end
    if (!rst && bus.out_meta_valid === 1'b1 && bus.out_meta_ready === 1'b1 && meta_n < LOGN) begin
      meta_ch[meta_n]   = bus.out_meta_channel;
      meta_data[meta_n] = bus.out_meta_data;
      meta_cyc[meta_n]  = cyc;
      meta_n++;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required one");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int            ch;
    logic          sop;
    logic          eop;
    logic [PW-1:0] data;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_flit(input int ch, input logic sop, input logic eop, input logic [PW-1:0] d);
    f_sop[ch][wr[ch]]  = sop;
    f_eop[ch][wr[ch]]  = eop;
    f_data[ch][wr[ch]] = d;
    wr[ch]++;
  endtask

  task automatic push_meta(input int ch, input logic [MW-1:0] d);
    m_store[ch][mwr[ch]] = d;
    mwr[ch]++;
  endtask

  task automatic wait_eops(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (mon_eop_n < target && k < budget) begin
      tick();
      k++;
    end
    check({name, "_done"}, 64'(mon_eop_n >= target), 64'd1);
  endtask

  task automatic check_log(input vec_t v, input int idx, input string name);
    check({name, "_ch"},    64'(mon_ch[idx]),    64'(v.ch));
    check({name, "_sop"},   64'(mon_sop[idx]),   64'(v.sop));
    check({name, "_eop"},   64'(mon_eop[idx]),   64'(v.eop));
    check({name, "_data"},  64'(mon_data[idx]),  64'(v.data));
    check({name, "_empty"}, 64'(mon_empty[idx]), 64'(v.data[EW-1:0]));
  endtask

  initial begin : stim
    vec_t t1 [12];
    vec_t t2 [4];
    vec_t t5 [4];
    int base, mbase, ebase;

    // ---- reset state ----
    do_reset();
    check("rst_meta_valid", 64'(bus.out_meta_valid), 64'd0);
    check("rst_pkt_valid",  64'(bus.out_pkt_valid),  64'd0);
    check("rst_pkt_ready",  64'(bus.in_pkt_ready),   64'd0);
    check("rst_meta_ready", 64'(bus.in_meta_ready),  64'd0);
    check("rst_grant_cnt",  64'(bus.grant_cnt == '0), 64'd1);
    check("rst_perr",       64'(bus.protocol_err),   64'd0);
    check("rst_pkt_chan",   64'(bus.out_pkt_channel),  64'd0);
    check("rst_meta_chan",  64'(bus.out_meta_channel), 64'd0);

    // ---- four 3-flit packets, grant order 0,1,2,3 ----
    for (int c = 0; c < N; c++)
      for (int f = 0; f < 3; f++)
        t1[c*3+f] = '{c, (f == 0), (f == 2), {4'hA, 4'(c), 8'(f)}};
    base = mon_n; mbase = meta_n; ebase = mon_eop_n;
    for (int c = 0; c < N; c++) push_meta(c, {4'hD, 4'(c), 8'h00});
    for (int k = 0; k < 12; k++) push_flit(t1[k].ch, t1[k].sop, t1[k].eop, t1[k].data);
    wait_eops(ebase + 4, 80, "rr4");
    repeat (3) tick();
    check("rr4_flit_count", 64'(mon_n - base), 64'd12);
    for (int k = 0; k < 12; k++) check_log(t1[k], base + k, "rr4");
    for (int c = 0; c < N; c++) begin
      check("rr4_meta_ch",   64'(meta_ch[mbase+c]),   64'(c));
      check("rr4_meta_data", 64'(meta_data[mbase+c]), 64'({4'hD, 4'(c), 8'h00}));
      if (c > 0) check("rr4_meta_spacing", 64'(meta_cyc[mbase+c] - meta_cyc[mbase+c-1]), 64'd5);
      check("rr4_grant_cnt", 64'(bus.grant_cnt[c*32 +: 32]), 64'd1);
    end

    // ---- requester 2 alone with toggling downstream ready ----
    do_reset();
    for (int f = 0; f < 4; f++) t2[f] = '{2, (f == 0), (f == 3), {4'hA, 4'h2, 8'(16 + f)}};
    base = mon_n; ebase = mon_eop_n;
    toggle = 1'b1;
    push_meta(2, {4'hD, 4'h2, 8'h01});
    for (int f = 0; f < 4; f++) push_flit(t2[f].ch, t2[f].sop, t2[f].eop, t2[f].data);
    wait_eops(ebase + 1, 80, "tog");
    toggle = 1'b0;
    repeat (3) tick();
    check("tog_flit_count", 64'(mon_n - base), 64'd4);
    for (int f = 0; f < 4; f++) check_log(t2[f], base + f, "tog");
    check("tog_cnt2", 64'(bus.grant_cnt[2*32 +: 32]), 64'd1);
    check("tog_cnt0", 64'(bus.grant_cnt[0 +: 32]),    64'd0);

    // ---- five back-to-back single-flit packets on requester 1 ----
    do_reset();
    base = mon_n; mbase = meta_n; ebase = mon_eop_n;
    for (int p = 0; p < 5; p++) begin
      push_meta(1, {4'hD, 4'h1, 8'(p)});
      push_flit(1, 1'b1, 1'b1, {4'hA, 4'h1, 8'(32 + p)});
    end
    wait_eops(ebase + 5, 80, "single");
    repeat (3) tick();
    check("single_flit_count", 64'(mon_n - base), 64'd5);
    for (int p = 0; p < 5; p++) begin
      check_log('{1, 1'b1, 1'b1, {4'hA, 4'h1, 8'(32 + p)}}, base + p, "single");
      check("single_meta_data", 64'(meta_data[mbase+p]), 64'({4'hD, 4'h1, 8'(p)}));
      if (p > 0) check("single_meta_spacing", 64'(meta_cyc[mbase+p] - meta_cyc[mbase+p-1]), 64'd3);
    end
    check("single_cnt1", 64'(bus.grant_cnt[1*32 +: 32]), 64'd5);

    // ---- almost_full blocks the grant; release gives meta two cycles later ----
    do_reset();
    ebase = mon_eop_n;
    af = 1'b1;
    push_meta(0, {4'hD, 4'h0, 8'h05});
    push_flit(0, 1'b1, 1'b0, {4'hA, 4'h0, 8'h50});
    push_flit(0, 1'b0, 1'b1, {4'hA, 4'h0, 8'h51});
    repeat (6) tick();
    check("af_meta_valid_blocked", 64'(bus.out_meta_valid), 64'd0);
    check("af_meta_ready_blocked", 64'(bus.in_meta_ready),  64'd0);
    check("af_pkt_valid_blocked",  64'(bus.out_pkt_valid),  64'd0);
    af = 1'b0;
    tick();
    check("af_release_idle",  64'(bus.out_meta_valid), 64'd0);
    tick();
    check("af_release_meta",  64'(bus.out_meta_valid),   64'd1);
    check("af_meta_chan",     64'(bus.out_meta_channel), 64'd0);
    check("af_meta_data",     64'(bus.out_meta_data),    64'({4'hD, 4'h0, 8'h05}));
    check("af_in_meta_ready", 64'(bus.in_meta_ready),    64'b0001);
    wait_eops(ebase + 1, 40, "af");
    check("af_pkt_chan_idle", 64'(bus.out_pkt_channel), 64'd0);

    // ---- second sop inside a packet on requester 3 ----
    t5[0] = '{3, 1'b1, 1'b0, 16'hA360};
    t5[1] = '{3, 1'b0, 1'b0, 16'hA361};
    t5[2] = '{3, 1'b1, 1'b0, 16'hA362};
    t5[3] = '{3, 1'b0, 1'b1, 16'hA363};
    check("perr_before", 64'(bus.protocol_err), 64'd0);
    base = mon_n; ebase = mon_eop_n;
    push_meta(3, {4'hD, 4'h3, 8'h06});
    for (int f = 0; f < 4; f++) push_flit(t5[f].ch, t5[f].sop, t5[f].eop, t5[f].data);
    wait_eops(ebase + 1, 40, "perr");
    check("perr_set", 64'(bus.protocol_err), 64'd1);
    repeat (3) tick();
    check("perr_sticky", 64'(bus.protocol_err), 64'd1);
    check("perr_flit_count", 64'(mon_n - base), 64'd4);
    for (int f = 0; f < 4; f++) check_log(t5[f], base + f, "perr");
    check("perr_cnt3", 64'(bus.grant_cnt[3*32 +: 32]), 64'd1);
    check("perr_cnt0", 64'(bus.grant_cnt[0 +: 32]),    64'd1);

    // ---- asynchronous reset in the middle of a 4-flit packet ----
    base = mon_n;
    push_meta(0, {4'hD, 4'h0, 8'h07});
    for (int f = 0; f < 4; f++) push_flit(0, (f == 0), (f == 3), {4'hA, 4'h0, 8'(112 + f)});
    begin
      int k;
      k = 0;
      while ((mon_n - base) < 2 && k < 40) begin
        tick();
        k++;
      end
    end
    check("mid_two_flits", 64'(mon_n - base), 64'd2);
    check("mid_in_pkt",    64'(bus.out_pkt_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_pkt_ready",  64'(bus.in_pkt_ready),   64'd0);
    check("mid_rst_meta_ready", 64'(bus.in_meta_ready),  64'd0);
    check("mid_rst_pkt_valid",  64'(bus.out_pkt_valid),  64'd0);
    check("mid_rst_meta_valid", 64'(bus.out_meta_valid), 64'd0);
    check("mid_rst_grant_cnt",  64'(bus.grant_cnt == '0), 64'd1);
    check("mid_rst_perr",       64'(bus.protocol_err),   64'd0);
    check("mid_rst_chan",       64'(bus.out_pkt_channel), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_idle_meta", 64'(bus.out_meta_valid), 64'd0);
    check("post_rst_idle_pkt",  64'(bus.out_pkt_valid),  64'd0);
    check("post_rst_no_flits",  64'(mon_n - base),       64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
